// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit.
// funct3 codes, status codes, FSM encoding and access classification.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_ILL = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Illegal encodings take priority over alignment.
    function automatic logic [1:0] check_access(
        input logic       ld,
        input logic       st,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic [1:0] e;
        e = ERR_OK;
        if (ld && st)
            e = ERR_ILL;
        else if (ld && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111))
            e = ERR_ILL;
        else if (st && f3 >= 3'b011)
            e = ERR_ILL;
        else if (f3[1:0] == 2'b10 && off != 2'b00)
            e = ERR_MIS;
        else if (f3[1:0] == 2'b01 && off[0])
            e = ERR_MIS;
        return e;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory req/ack bus between the LSU and memory.
// The LSU drives the request side through the master modport.
interface lsu_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/lsu_lane.sv
// Byte-lane logic: store enables/replication and load lane extraction.
// Purely combinational; the store side sees live inputs, the load side latched ones.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic        st_en,
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be    = 4'b1111;
        wdata = '0;
        if (st_en) begin
            wdata = st_data;
            unique case (1'b1)
                (st_funct3 == F3_SB): begin
                    be    = 4'b0001 << st_off;
                    wdata = {4{st_data[7:0]}};
                end
                (st_funct3 == F3_SH): begin
                    be    = 4'b0011 << {st_off[1], 1'b0};
                    wdata = {2{st_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        byte_sel = rdata[{ld_off, 3'b000} +: 8];
        half_sel = ld_off[1] ? rdata[31:16] : rdata[15:0];
        ld_value = '0;
        unique case (1'b1)
            (ld_funct3 == F3_LB):  ld_value = {{24{byte_sel[7]}}, byte_sel};
            (ld_funct3 == F3_LH):  ld_value = {{16{half_sel[15]}}, half_sel};
            (ld_funct3 == F3_LW):  ld_value = rdata;
            (ld_funct3 == F3_LBU): ld_value = {24'd0, byte_sel};
            (ld_funct3 == F3_LHU): ld_value = {16'd0, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one req/ack memory transaction per accepted start.
// Misaligned, illegal and non-memory requests complete without touching the bus.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic [1:0]  err_code,
    lsu_if.master       bus
);

    localparam logic [7:0] TMO = TIMEOUT[7:0];

    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        ld_q;
    logic [1:0]  acc_err;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] ld_value;

    assign acc_err = check_access(is_load, is_store, funct3, addr[1:0]);

    lsu_lane u_lane (
        .st_en     (is_store),
        .st_funct3 (funct3),
        .st_off    (addr[1:0]),
        .st_data   (store_data),
        .be        (lane_be),
        .wdata     (lane_wdata),
        .ld_funct3 (f3_q),
        .ld_off    (off_q),
        .rdata     (bus.mem_rdata),
        .ld_value  (ld_value)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            load_data     <= '0;
            err_code      <= ERR_OK;
            cnt           <= '0;
            f3_q          <= '0;
            off_q         <= '0;
            ld_q          <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        f3_q      <= funct3;
                        off_q     <= addr[1:0];
                        ld_q      <= is_load;
                        load_data <= '0;
                        busy      <= 1'b1;
                        if (!is_load && !is_store) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            err_code <= ERR_OK;
                        end else if (acc_err != ERR_OK) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            err_code <= acc_err;
                        end else begin
                            state         <= S_REQ;
                            err_code      <= ERR_OK;
                            cnt           <= '0;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= is_store;
                            bus.mem_addr  <= {addr[31:2], 2'b00};
                            bus.mem_be    <= lane_be;
                            bus.mem_wdata <= lane_wdata;
                        end
                    end
                end
                S_REQ: begin
                    // An ack on the final wait cycle still counts as success.
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        state       <= S_DONE;
                        done        <= 1'b1;
                        err_code    <= ERR_OK;
                        load_data   <= ld_q ? ld_value : '0;
                    end else if (cnt + 8'd1 == TMO) begin
                        bus.mem_req <= 1'b0;
                        state       <= S_DONE;
                        done        <= 1'b1;
                        err_code    <= ERR_TMO;
                        load_data   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu checked against a transaction-level model.
// Expected outputs per cycle come from the model; one process compares them.
module tb_lsu;

    localparam int TMO = 4;

    typedef struct packed {
        logic        acc;
        logic [1:0]  err;
        logic [31:0] ld;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic [1:0]  err_code;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    lsu_if mem_bus ();
    assign mem_bus.mem_ack   = mem_ack;
    assign mem_bus.mem_rdata = mem_rdata;

    lsu #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .err_code   (err_code),
        .bus        (mem_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int fails   = 0;

    logic        chk_en = 1'b0;
    logic        chk_bus = 1'b0;
    logic        chk_res = 1'b0;
    logic        exp_busy, exp_done, exp_req, exp_we;
    logic [31:0] exp_addr, exp_wd, exp_ld;
    logic [3:0]  exp_be;
    logic [1:0]  exp_err;
    logic [31:0] last_ld = '0;
    logic [1:0]  last_err = '0;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("busy", 32'(busy), 32'(exp_busy));
            cmp("done", 32'(done), 32'(exp_done));
            cmp("mem_req", 32'(mem_bus.mem_req), 32'(exp_req));
            if (chk_bus) begin
                cmp("mem_addr", mem_bus.mem_addr, exp_addr);
                cmp("mem_be", 32'(mem_bus.mem_be), 32'(exp_be));
                cmp("mem_we", 32'(mem_bus.mem_we), 32'(exp_we));
                if (exp_we)
                    cmp("mem_wdata", mem_bus.mem_wdata, exp_wd);
            end
            if (chk_res) begin
                cmp("load_data", load_data, exp_ld);
                cmp("err_code", 32'(err_code), 32'(exp_err));
            end
        end
    end

    // Outcome of one request, w = wait cycles before ack (w >= TMO: never).
    function automatic exp_t model(input bit ld, input bit st,
                                   input bit [2:0] f3, input bit [31:0] a,
                                   input bit [31:0] sd, input bit [31:0] rd,
                                   input int w);
        exp_t e;
        int size;
        int off;
        bit legal;
        bit [31:0] lane;
        bit [31:0] mask;
        e = '0;
        e.be = 4'hF;
        off = int'(a % 4);
        if (!ld && !st) return e;
        if (ld && st) begin
            e.err = 2'd2;
            return e;
        end
        if (ld) legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        else    legal = (f3 <= 2);
        if (!legal) begin
            e.err = 2'd2;
            return e;
        end
        size = 1 << f3[1:0];
        if (off % size != 0) begin
            e.err = 2'd1;
            return e;
        end
        e.acc = 1'b1;
        e.we  = st;
        if (st) begin
            e.be = 4'((1 << size) - 1) << off;
            if (size == 1)      e.wd = 32'(sd[7:0]) * 32'h0101_0101;
            else if (size == 2) e.wd = 32'(sd[15:0]) * 32'h0001_0001;
            else                e.wd = sd;
        end
        if (w >= TMO) begin
            e.err = 2'd3;
            return e;
        end
        if (ld) begin
            lane = rd >> (8 * off);
            mask = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 1;
            lane = lane & mask;
            if (!f3[2] && size < 4 && lane[8 * size - 1]) lane = lane | ~mask;
            e.ld = lane;
        end
        return e;
    endfunction

    task automatic set_idle();
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_req  = 1'b0;
        chk_bus  = 1'b0;
        chk_res  = 1'b1;
        exp_ld   = last_ld;
        exp_err  = last_err;
    endtask

    task automatic junk_inputs();
        start      = 1'($urandom_range(0, 1));
        is_load    = 1'($urandom_range(0, 1));
        is_store   = 1'($urandom_range(0, 1));
        funct3     = 3'($urandom);
        addr       = $urandom;
        store_data = $urandom;
    endtask

    task automatic idle_cycle();
        start     = 1'b0;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        set_idle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input bit ld, input bit st, input bit [2:0] f3,
                           input bit [31:0] a, input bit [31:0] sd,
                           input bit [31:0] rd, input int w);
        exp_t e;
        int nd;
        e  = model(ld, st, f3, a, sd, rd, w);
        nd = !e.acc ? 1 : (w < TMO ? w + 2 : TMO + 1);
        start      = 1'b1;
        is_load    = ld;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        mem_ack    = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        set_idle();
        for (int c = 1; c <= nd; c++) begin
            @(posedge clk);
            #1;
            junk_inputs();
            exp_busy = 1'b1;
            exp_done = (c == nd);
            exp_req  = e.acc && (c < nd);
            chk_bus  = exp_req;
            exp_addr = {a[31:2], 2'b00};
            exp_be   = e.be;
            exp_we   = e.we;
            exp_wd   = e.wd;
            chk_res  = (c == nd);
            exp_ld   = e.ld;
            exp_err  = e.err;
            if (e.acc && c < nd) begin
                mem_ack   = (c == w + 1);
                mem_rdata = (c == w + 1) ? rd : $urandom;
            end else begin
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
        end
        last_ld  = e.ld;
        last_err = e.err;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_reset_mid();
        start      = 1'b1;
        is_load    = 1'b1;
        is_store   = 1'b0;
        funct3     = 3'b010;
        addr       = 32'h0000_4000;
        store_data = '0;
        mem_ack    = 1'b0;
        set_idle();
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            start   = 1'b0;
            rst     = (c == 2);
            mem_ack = (c >= 3);
            exp_busy = (c <= 2);
            exp_done = 1'b0;
            exp_req  = (c <= 2);
            chk_bus  = 1'b1;
            exp_addr = (c <= 2) ? 32'h0000_4000 : 32'h0;
            exp_be   = (c <= 2) ? 4'hF : 4'h0;
            exp_we   = 1'b0;
            chk_res  = (c >= 3);
            exp_ld   = '0;
            exp_err  = '0;
        end
        last_ld  = '0;
        last_err = '0;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
    endtask

    task automatic pin_model();
        exp_t e;
        e = model(1, 0, 3'b000, 32'h1003, 0, 32'h80FF_FF12, 0);
        cmp("pin_lb_ld", e.ld, 32'hFFFF_FF80);
        cmp("pin_lb_be", 32'(e.be), 32'hF);
        e = model(1, 0, 3'b101, 32'h2002, 0, 32'hBEEF_1234, 1);
        cmp("pin_lhu_ld", e.ld, 32'h0000_BEEF);
        e = model(1, 0, 3'b001, 32'h2002, 0, 32'hBEEF_1234, 1);
        cmp("pin_lh_ld", e.ld, 32'hFFFF_BEEF);
        e = model(0, 1, 3'b000, 32'h3001, 32'hDEAD_BEAB, 0, 0);
        cmp("pin_sb_be", 32'(e.be), 32'h2);
        cmp("pin_sb_wd", e.wd, 32'hABAB_ABAB);
        e = model(0, 1, 3'b001, 32'h3002, 32'h0000_5A5A, 0, 0);
        cmp("pin_sh_be", 32'(e.be), 32'hC);
        cmp("pin_sh_wd", e.wd, 32'h5A5A_5A5A);
        e = model(1, 0, 3'b010, 32'h6, 0, 0, 0);
        cmp("pin_lw_mis", 32'(e.err), 32'h1);
        e = model(1, 0, 3'b110, 32'h0, 0, 0, 0);
        cmp("pin_ill", 32'(e.err), 32'h2);
        e = model(1, 0, 3'b010, 32'h0, 0, 32'h1234_5678, 100);
        cmp("pin_tmo", 32'(e.err), 32'h3);
        cmp("pin_tmo_ld", e.ld, 32'h0);
    endtask

    initial begin
        bit ld, st;
        int r;
        rst        = 1'b1;
        start      = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        funct3     = '0;
        addr       = '0;
        store_data = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        pin_model();
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        set_idle();
        chk_bus  = 1'b1;
        exp_addr = '0;
        exp_be   = '0;
        exp_we   = 1'b0;
        chk_en   = 1'b1;
        @(posedge clk);
        #1;
        run_txn(1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FF_FF12, 0);
        run_txn(1, 0, 3'b101, 32'h2002, 32'h0, 32'hBEEF_1234, 1);
        run_txn(1, 0, 3'b001, 32'h2002, 32'h0, 32'hBEEF_1234, 2);
        run_txn(0, 1, 3'b000, 32'h3001, 32'hDEAD_BEAB, 32'h0, 0);
        run_txn(0, 1, 3'b001, 32'h3002, 32'h0000_5A5A, 32'h0, 1);
        run_txn(1, 0, 3'b010, 32'h6, 32'h0, 32'h0, 0);
        run_txn(1, 0, 3'b110, 32'h100, 32'h0, 32'h0, 0);
        run_txn(1, 0, 3'b010, 32'h5000, 32'h0, 32'hCAFE_F00D, 100);
        run_txn(1, 0, 3'b010, 32'h5004, 32'h0, 32'hCAFE_F00D, 3);
        run_txn(0, 0, 3'b010, 32'h0, 32'h0, 32'h0, 0);
        idle_cycle();
        run_reset_mid();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            ld = (r == 1) || (r >= 2 && r <= 5);
            st = (r == 1) || (r >= 6);
            run_txn(ld, st, 3'($urandom),
                    $urandom_range(0, 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom,
                    $urandom, $urandom, $urandom_range(0, TMO + 1));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        chk_en = 1'b0;
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
